uart_rx_core: RTL and testbench



---
 rtl/uart_rx_core.sv | 157 +++++++++++++++
 tb/tb_uart_rx_core.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// UART receiver: oversampled, 3-sample majority vote, start/data/parity/stop deframing.
// Optional macro UART_RX_SYNC_EN adds a 2-flop input synchronizer on rx_in.
module uart_rx_core #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [PRESCALE_W-1:0] P8  = PRESCALE_W'(8);
    localparam logic [PRESCALE_W-1:0] P16 = PRESCALE_W'(16);
    localparam logic [PRESCALE_W-1:0] P32 = PRESCALE_W'(32);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                  r_state;
    logic [PRESCALE_W-1:0]   r_edge_cnt;
    logic [BIT_W-1:0]        r_bit_cnt;
    logic [PRESCALE_W-1:0]   r_prescale;
    logic                    r_par_en;
    logic                    r_par_typ;
    logic                    r_par_fail;
    logic                    r_s0, r_s1, r_s2;
    logic [DATA_WIDTH-1:0]   r_data;

    logic                    w_rx;
    logic [PRESCALE_W-1:0]   w_half;
    logic                    w_end_bit;
    logic                    w_vote;
    logic                    w_legal;
    logic                    w_exp_par;

`ifdef UART_RX_SYNC_EN
    logic r_sync1, r_sync2;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_in;
            r_sync2 <= r_sync1;
        end
    end
    assign w_rx = r_sync2;
`else
    assign w_rx = rx_in;
`endif

    assign w_half    = {1'b0, r_prescale[PRESCALE_W-1:1]};
    assign w_end_bit = (r_edge_cnt == r_prescale - PRESCALE_W'(1));
    assign w_vote    = (r_s0 & r_s1) | (r_s0 & r_s2) | (r_s1 & r_s2);
    assign w_legal   = (prescale == P8) || (prescale == P16) || (prescale == P32);
    assign w_exp_par = (^r_data) ^ r_par_typ;

    // Datapath: mid-bit samples and the shift-in of voted data bits need no reset.
    always_ff @(posedge clk) begin
        if (r_state != IDLE) begin
            if (r_edge_cnt == w_half - PRESCALE_W'(2)) r_s0 <= w_rx;
            if (r_edge_cnt == w_half - PRESCALE_W'(1)) r_s1 <= w_rx;
            if (r_edge_cnt == w_half)                  r_s2 <= w_rx;
        end
        if (r_state == DATA && w_end_bit) r_data[r_bit_cnt] <= w_vote;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            r_prescale <= P8;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_par_fail <= 1'b0;
            p_data     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            if (r_state != IDLE) r_edge_cnt <= w_end_bit ? '0 : r_edge_cnt + PRESCALE_W'(1);
            case (r_state)
                IDLE: begin
                    // The detection cycle is edge 0, so the start bit continues from edge 1.
                    if (!w_rx) begin
                        r_state    <= START;
                        r_edge_cnt <= PRESCALE_W'(1);
                        r_bit_cnt  <= '0;
                        r_prescale <= w_legal ? prescale : P8;
                        r_par_en   <= par_en;
                        r_par_typ  <= par_typ;
                        r_par_fail <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                START: begin
                    if (w_end_bit) begin
                        if (w_vote) begin
                            r_state <= IDLE;
                            busy    <= 1'b0;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_end_bit) begin
                        if (r_bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
                            r_bit_cnt <= '0;
                            r_state   <= r_par_en ? PARITY : STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (w_end_bit) begin
                        r_par_fail <= (w_vote != w_exp_par);
                        r_state    <= STOP;
                    end
                end
                STOP: begin
                    if (w_end_bit) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                        if (!w_vote) begin
                            stp_err <= 1'b1;
                        end else if (r_par_fail) begin
                            par_err <= 1'b1;
                        end else begin
                            p_data     <= r_data;
                            data_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboarded bench for uart_rx_core: directed frames plus randomized frames,
// with the expected outcome of each frame derived from the frame contents.
module tb_uart_rx_core;

    localparam int DW = 8;
    localparam int PW = 6;

    localparam logic [2:0] K_DV = 3'b001;
    localparam logic [2:0] K_PE = 3'b010;
    localparam logic [2:0] K_SE = 3'b100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_in = 1'b1;
    logic [PW-1:0] prescale = PW'(8);
    logic          par_en = 1'b0;
    logic          par_typ = 1'b0;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;
    logic          busy;

    uart_rx_core #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale),
        .par_en(par_en), .par_typ(par_typ), .p_data(p_data),
        .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [2:0]    kind;
        logic [DW-1:0] data;
        int            at;
    } exp_t;

    exp_t          sbq[$];
    exp_t          mon_e;
    logic [DW-1:0] last_good = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every output pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && (data_valid || par_err || stp_err)) begin
            if (sbq.size() == 0) begin
                check("unexpected_pulse", {29'd0, stp_err, par_err, data_valid}, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                check("pulse_kind", {29'd0, stp_err, par_err, data_valid}, {29'd0, mon_e.kind});
                check("p_data", {24'd0, p_data}, {24'd0, mon_e.data});
                check("pulse_cycle", cyc, mon_e.at);
                check("busy_at_end", {31'd0, busy}, 32'd0);
            end
        end
    end

    function automatic int eff_p(input logic [PW-1:0] p);
        return (p == PW'(8) || p == PW'(16) || p == PW'(32)) ? int'(p) : 8;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_in = 1'b1;
        end
    endtask

    // spike_bit: frame bit index (1..DW) that gets a one-cycle inversion at edge P/2-1.
    // abort_at: cycle offset from t0 where reset is pulsed (negative = no abort).
    task automatic send_frame(input logic [DW-1:0] d, input logic [PW-1:0] pin,
                              input logic pe, input logic pt, input logic pbit,
                              input logic sbit, input int spike_bit, input int abort_at);
        int   peff;
        int   t0;
        logic bits[$];
        exp_t ev;
        peff = eff_p(pin);
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(d[i]);
        if (pe) bits.push_back(pbit);
        bits.push_back(sbit);
        t0 = 0;
        for (int k = 0; k < bits.size(); k++) begin
            for (int ee = 0; ee < peff; ee++) begin
                @(negedge clk);
                if (k == 0 && ee == 0) begin
                    prescale = pin;
                    par_en   = pe;
                    par_typ  = pt;
                    t0       = cyc;
                    if (abort_at < 0) begin
                        ev.at = t0 + bits.size() * peff;
                        if (!sbit) begin
                            ev.kind = K_SE;
                            ev.data = last_good;
                        end else if (pe && ((($countones(d) + int'(pbit)) % 2) != int'(pt))) begin
                            ev.kind = K_PE;
                            ev.data = last_good;
                        end else begin
                            ev.kind   = K_DV;
                            ev.data   = d;
                            last_good = d;
                        end
                        sbq.push_back(ev);
                    end
                end else if (k == 0 && ee == 1) begin
                    check("busy_after_start", {31'd0, busy}, 32'd1);
                    prescale = PW'($urandom_range(0, 63));
                    par_en   = 1'($urandom);
                    par_typ  = 1'($urandom);
                end
                if (abort_at >= 0 && k * peff + ee == abort_at) begin
                    rst   = 1'b1;
                    rx_in = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    check("abort_p_data", {24'd0, p_data}, 32'd0);
                    check("abort_flags", {28'd0, busy, stp_err, par_err, data_valid}, 32'd0);
                    last_good = '0;
                    return;
                end
                rx_in = bits[k] ^ (k == spike_bit && ee == peff / 2 - 1);
            end
        end
    endtask

    task automatic glitch(input logic [PW-1:0] pin);
        int peff;
        int t0;
        peff = eff_p(pin);
        @(negedge clk);
        prescale = pin;
        rx_in    = 1'b0;
        t0       = cyc;
        @(negedge clk);
        rx_in = 1'b0;
        @(negedge clk);
        rx_in    = 1'b1;
        prescale = PW'($urandom_range(0, 63));
        while (cyc < t0 + peff - 1) @(negedge clk);
        check("glitch_busy_start", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("glitch_back_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        logic [PW-1:0] pin;
        int            sel;
        int            spk;
        int            w;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_p_data", {24'd0, p_data}, 32'd0);
        check("reset_flags", {28'd0, busy, stp_err, par_err, data_valid}, 32'd0);
        rst = 1'b0;
        idle(2);

        send_frame(8'hA5, PW'(8), 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(3);
        send_frame(8'h3C, PW'(16), 1'b1, 1'b0, 1'b0, 1'b1, -1, -1);
        send_frame(8'h3C, PW'(16), 1'b1, 1'b0, 1'b1, 1'b1, -1, -1);
        idle(2);
        send_frame(8'h5A, PW'(8), 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
        send_frame(8'h0F, PW'(8), 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(2);
        glitch(PW'(8));
        idle(2);
        send_frame(8'h96, PW'(8), 1'b0, 1'b0, 1'b0, 1'b1, 3, -1);
        idle(2);
        send_frame(8'h77, PW'(8), 1'b0, 1'b0, 1'b0, 1'b1, -1, 40);
        idle(2);
        send_frame(8'hC3, PW'(8), 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(1);
        send_frame(8'hFF, PW'(32), 1'b1, 1'b1, 1'b1, 1'b1, -1, -1);
        send_frame(8'hFF, PW'(12), 1'b1, 1'b1, 1'b1, 1'b1, -1, -1);
        idle(2);

        for (int n = 0; n < 40; n++) begin
            d   = DW'($urandom);
            sel = $urandom_range(0, 3);
            if (sel == 0)      pin = PW'(8);
            else if (sel == 1) pin = PW'(16);
            else if (sel == 2) pin = PW'(32);
            else begin
                pin = PW'($urandom_range(0, 63));
                while (pin == PW'(8) || pin == PW'(16) || pin == PW'(32)) pin = PW'($urandom_range(0, 63));
            end
            spk = ($urandom_range(0, 2) == 0) ? $urandom_range(1, DW) : -1;
            if ($urandom_range(0, 9) == 0) begin
                idle(1);
                glitch(pin);
            end
            send_frame(d, pin, 1'($urandom), 1'($urandom), 1'($urandom),
                       1'($urandom_range(0, 7) != 0), spk, -1);
            idle($urandom_range(0, 2));
        end

        rx_in = 1'b1;
        w = 0;
        while (sbq.size() != 0 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check("scoreboard_drained", sbq.size(), 32'd0);
        check("final_p_data", {24'd0, p_data}, {24'd0, last_good});
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
